// File: rtl/fft_pkg.sv
// Shared types and fixed-point helpers for the streaming SDF FFT stages.
// Helpers work on a wide signed accumulator; callers narrow the result.
package fft_pkg;

    localparam int FFT_DATA_W     = 8;
    localparam int ACC_W          = 48;
    localparam int TW_MODE_BYPASS = 0;
    localparam int TW_MODE_MUL    = 1;

    typedef struct packed {
        logic signed [FFT_DATA_W-1:0] re;
        logic signed [FFT_DATA_W-1:0] im;
    } cplx_t;

    typedef logic signed [ACC_W-1:0] acc_t;

    // Clamp x to the signed range of a w-bit value.
    function automatic acc_t sat(input acc_t x, input int w);
        acc_t hi, lo;
        hi = (acc_t'(1) <<< (w - 1)) - acc_t'(1);
        lo = -(acc_t'(1) <<< (w - 1));
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

    // Round half up, then drop sh fractional bits.
    function automatic acc_t round(input acc_t x, input int sh);
        return (x + (acc_t'(1) <<< (sh - 1))) >>> sh;
    endfunction

endpackage

// File: rtl/cplx_mul_rnd.sv
// Combinational complex multiply by a Q1.(TW_W-1) twiddle with
// round-half-up and saturation back to DATA_W.
module cplx_mul_rnd
    import fft_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int TW_W   = 8
) (
    input  logic signed [DATA_W-1:0] a_re,
    input  logic signed [DATA_W-1:0] a_im,
    input  logic signed [TW_W-1:0]   w_re,
    input  logic signed [TW_W-1:0]   w_im,
    output logic signed [DATA_W-1:0] p_re,
    output logic signed [DATA_W-1:0] p_im
);

    acc_t pr, pi;

    always_comb begin
        pr   = acc_t'(a_re) * acc_t'(w_re) - acc_t'(a_im) * acc_t'(w_im);
        pi   = acc_t'(a_re) * acc_t'(w_im) + acc_t'(a_im) * acc_t'(w_re);
        p_re = DATA_W'(sat(round(pr, TW_W - 1), DATA_W));
        p_im = DATA_W'(sat(round(pi, TW_W - 1), DATA_W));
    end

endmodule

// File: rtl/r2sdf_stage.sv
// One radix-2 single-path delay-feedback FFT stage: butterfly against a
// DELAY-deep feedback line, twiddle on the difference branch, registered output.
module r2sdf_stage
    import fft_pkg::*;
#(
    parameter  int DATA_W  = 8,
    parameter  int DELAY   = 4,
    parameter  int TW_W    = 8,
    parameter  int TW_MODE = 1,
    parameter  int SCALE   = 1,
    localparam int IW      = (DELAY > 1) ? $clog2(DELAY) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [2*DATA_W-1:0]    in_data,
    output logic [IW-1:0]          tw_idx,
    input  logic signed [TW_W-1:0] tw_re,
    input  logic signed [TW_W-1:0] tw_im,
    output logic                   out_valid,
    output logic [2*DATA_W-1:0]    out_data
);

    localparam int CW = $clog2(2 * DELAY);

    typedef struct packed {
        logic signed [DATA_W-1:0] re;
        logic signed [DATA_W-1:0] im;
    } smp_t;

    logic [CW-1:0] cnt;
    logic          primed;
    logic          bfly;
    smp_t          dly [DELAY];
    smp_t          head, din, sum, dif, twd, emit, push;

    // Butterfly result narrowing: halve, or saturate when unscaled.
    function automatic logic signed [DATA_W-1:0] s_fn(input acc_t x);
        if (SCALE != 0) return DATA_W'(x >>> 1);
        return DATA_W'(sat(x, DATA_W));
    endfunction

    assign din  = smp_t'(in_data);
    assign head = dly[DELAY-1];
    assign bfly = cnt[CW-1];

    generate
        if (DELAY > 1) begin : g_idx
            assign tw_idx = cnt[IW-1:0];
        end else begin : g_idx1
            assign tw_idx = '0;
        end
    endgenerate

    cplx_mul_rnd #(.DATA_W(DATA_W), .TW_W(TW_W)) u_mul (
        .a_re (head.re),
        .a_im (head.im),
        .w_re (tw_re),
        .w_im (tw_im),
        .p_re (twd.re),
        .p_im (twd.im)
    );

    always_comb begin
        sum.re = s_fn(acc_t'(head.re) + acc_t'(din.re));
        sum.im = s_fn(acc_t'(head.im) + acc_t'(din.im));
        dif.re = s_fn(acc_t'(head.re) - acc_t'(din.re));
        dif.im = s_fn(acc_t'(head.im) - acc_t'(din.im));
        push   = bfly ? dif : din;
        if (bfly)                     emit = sum;
        else if (TW_MODE == TW_MODE_MUL) emit = twd;
        else                          emit = head;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            primed    <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            for (int i = 0; i < DELAY; i++) dly[i] <= '0;
        end else if (in_valid) begin
            cnt <= cnt + CW'(1);
            if (&cnt) primed <= 1'b1;
            dly[0] <= push;
            for (int i = 1; i < DELAY; i++) dly[i] <= dly[i-1];
            // Fill-phase outputs of the very first frame are just buffer zeros.
            out_valid <= primed | bfly;
            if (primed | bfly) out_data <= emit;
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_r2sdf_stage.sv
// Directed bench for r2sdf_stage: three configurations (DELAY=1 bypass,
// DELAY=1 with -j twiddle, DELAY=2 unscaled with a two-entry ROM).
module tb_r2sdf_stage;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        v1, v2, v3;
    logic [15:0] d1, d2, d3;
    logic [15:0] o1, o2, o3;
    logic        ov1, ov2, ov3;
    logic [0:0]  ix1, ix2, ix3;
    logic signed [7:0] t1r, t1i, t2r, t2i, t3r, t3i;

    assign t1r = 8'h00;
    assign t1i = 8'h00;
    assign t2r = 8'h00;
    assign t2i = 8'h80;
    assign t3r = (ix3 == 1'b0) ? 8'h7f : 8'h00;
    assign t3i = (ix3 == 1'b0) ? 8'h00 : 8'h80;

    r2sdf_stage #(.DATA_W(8), .DELAY(1), .TW_W(8), .TW_MODE(0), .SCALE(1)) u1 (
        .clk(clk), .rst(rst), .in_valid(v1), .in_data(d1), .tw_idx(ix1),
        .tw_re(t1r), .tw_im(t1i), .out_valid(ov1), .out_data(o1));
    r2sdf_stage #(.DATA_W(8), .DELAY(1), .TW_W(8), .TW_MODE(1), .SCALE(1)) u2 (
        .clk(clk), .rst(rst), .in_valid(v2), .in_data(d2), .tw_idx(ix2),
        .tw_re(t2r), .tw_im(t2i), .out_valid(ov2), .out_data(o2));
    r2sdf_stage #(.DATA_W(8), .DELAY(2), .TW_W(8), .TW_MODE(1), .SCALE(0)) u3 (
        .clk(clk), .rst(rst), .in_valid(v3), .in_data(d3), .tw_idx(ix3),
        .tw_re(t3r), .tw_im(t3i), .out_valid(ov3), .out_data(o3));

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] pk(input int re, input int im);
        return {re[7:0], im[7:0]};
    endfunction

    // One clock: drive unit u, optionally check tw_idx, then check the
    // registered output produced by this cycle's input.
    task automatic cyc(input int u, input logic v, input int re, input int im,
                       input logic ev, input int ere, input int eim,
                       input int etw, input string tag);
        logic [15:0] d, od;
        logic        ov, ix;
        d = pk(re, im);
        case (u)
            1: begin v1 = v; d1 = d; end
            2: begin v2 = v; d2 = d; end
            default: begin v3 = v; d3 = d; end
        endcase
        if (etw >= 0) begin
            ix = (u == 1) ? ix1[0] : (u == 2) ? ix2[0] : ix3[0];
            chk({tag, ".idx"}, 32'(ix), 32'(etw));
        end
        @(posedge clk);
        #1;
        ov = (u == 1) ? ov1 : (u == 2) ? ov2 : ov3;
        od = (u == 1) ? o1  : (u == 2) ? o2  : o3;
        chk({tag, ".v"}, 32'(ov), 32'(ev));
        if (ev) chk({tag, ".d"}, 32'(od), 32'(pk(ere, eim)));
    endtask

    task automatic do_rst(input string tag);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk({tag, ".v1"}, 32'(ov1), 32'd0);
        chk({tag, ".v2"}, 32'(ov2), 32'd0);
        chk({tag, ".v3"}, 32'(ov3), 32'd0);
        chk({tag, ".d1"}, 32'(o1), 32'd0);
        chk({tag, ".d2"}, 32'(o2), 32'd0);
        chk({tag, ".d3"}, 32'(o3), 32'd0);
        rst = 1'b0;
        v1 = 1'b0;
    endtask

    task automatic scen1(input string tag);
        cyc(1, 1, 4, 2, 0, 0, 0, -1, {tag, ".i1"});
        cyc(1, 1, 2, 0, 1, 3, 1, -1, {tag, ".i2"});
        cyc(1, 1, 0, 0, 1, 1, 1, -1, {tag, ".i3"});
        cyc(1, 1, 0, 0, 1, 0, 0, -1, {tag, ".i4"});
    endtask

    initial begin
        rst = 1'b1;
        v1 = 0; v2 = 0; v3 = 0;
        d1 = '0; d2 = '0; d3 = '0;
        repeat (2) @(posedge clk);
        #1;
        do_rst("reset");

        // DELAY=1 bypass, then a negative odd pair (floor on halving)
        scen1("s1");
        cyc(1, 1, -3, 1, 1, 0, 0, -1, "s1.n1");
        cyc(1, 1, 0, 0, 1, -2, 0, -1, "s1.n2");
        cyc(1, 1, 0, 0, 1, -2, 0, -1, "s1.n3");
        cyc(1, 0, 0, 0, 0, 0, 0, -1, "s1.idle");

        // stalls between every sample
        do_rst("rst4");
        cyc(1, 1, 4, 2, 0, 0, 0, -1, "s4.i1");
        repeat (3) cyc(1, 0, 7, 7, 0, 0, 0, -1, "s4.st1");
        cyc(1, 1, 2, 0, 1, 3, 1, -1, "s4.i2");
        repeat (3) cyc(1, 0, 7, 7, 0, 0, 0, -1, "s4.st2");
        cyc(1, 1, 0, 0, 1, 1, 1, -1, "s4.i3");
        repeat (3) cyc(1, 0, 7, 7, 0, 0, 0, -1, "s4.st3");
        cyc(1, 1, 0, 0, 1, 0, 0, -1, "s4.i4");

        // reset mid-frame, with a valid sample presented during reset
        do_rst("rst5a");
        cyc(1, 1, 4, 2, 0, 0, 0, -1, "s5.i1");
        v1 = 1'b1;
        d1 = pk(9, 9);
        do_rst("rst5b");
        scen1("s5");
        v1 = 1'b0;

        // DELAY=1 with twiddle -j, including rounding and saturation
        cyc(2, 1, 4, 2, 0, 0, 0, 0, "s2.i1");
        cyc(2, 1, 2, 0, 1, 3, 1, -1, "s2.i2");
        cyc(2, 1, 0, 0, 1, 1, -1, 0, "s2.i3");
        cyc(2, 1, 0, 0, 1, 0, 0, -1, "s2.i4");
        cyc(2, 1, 100, -50, 1, 0, 0, -1, "s2.i5");
        cyc(2, 1, -100, 50, 1, 0, 0, -1, "s2.i6");
        cyc(2, 1, -128, 0, 1, -50, -100, -1, "s2.i7");
        cyc(2, 1, 127, 0, 1, -1, 0, -1, "s2.i8");
        cyc(2, 1, 0, 0, 1, 0, 127, -1, "s2.i9");
        cyc(2, 0, 0, 0, 0, 0, 0, -1, "s2.idle");

        // DELAY=2, unscaled with saturation, ROM {127+0j, -j}
        cyc(3, 1, 100, 0, 0, 0, 0, 0, "s3.i1");
        cyc(3, 1, 0, 0, 0, 0, 0, 1, "s3.i2");
        cyc(3, 1, 100, 0, 1, 127, 0, -1, "s3.i3");
        cyc(3, 1, 0, 0, 1, 0, 0, -1, "s3.i4");
        cyc(3, 1, 10, 20, 1, 0, 0, 0, "s3.f1");
        cyc(3, 1, -100, 5, 1, 0, 0, 1, "s3.f2");
        cyc(3, 1, 2, 4, 1, 12, 24, -1, "s3.f3");
        cyc(3, 1, -100, -1, 1, -128, 4, -1, "s3.f4");
        cyc(3, 1, 0, 0, 1, 8, 16, 0, "s3.fl1");
        cyc(3, 1, 0, 0, 1, 6, 0, 1, "s3.fl2");
        cyc(3, 0, 0, 0, 0, 0, 0, -1, "s3.idle");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
